// File: rtl/thermo_sweep_sequencer.sv
// Thermometer-code sweep sequencer for unary DAC / current-switch arrays.
// Ramp-down, ramp-up or triangle sweeps with runtime dwell, looping and abort.
module thermo_sweep_sequencer #(
  parameter int N_ARRAY     = 47,
  parameter int DWELL_WIDTH = 16,
  parameter int IDX_WIDTH   = $clog2(2*N_ARRAY+2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic                   loop,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [N_ARRAY-1:0]     ctrl,
  output logic [IDX_WIDTH-1:0]   step_idx,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] M_DOWN = 2'd0;
  localparam logic [1:0] M_UP   = 2'd1;
  localparam logic [1:0] M_TRI  = 2'd2;

  localparam logic [IDX_WIDTH-1:0] NK = IDX_WIDTH'(N_ARRAY);
  localparam logic [IDX_WIDTH-1:0] N2 = IDX_WIDTH'(2*N_ARRAY);

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic                   loop_q, loop_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [N_ARRAY-1:0]     ctrl_q, ctrl_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [1:0]           mode_n;
  logic [IDX_WIDTH-1:0] last;
  logic                 dwell_end;
  logic                 fin;

  // Level k for sweep position i; triangle folds back at the bottom.
  function automatic logic [IDX_WIDTH-1:0] level(
    input logic [1:0]           m,
    input logic [IDX_WIDTH-1:0] i
  );
    if (m == M_UP)
      return i;
    if (m == M_TRI && i > NK)
      return i - NK;
    return NK - i;
  endfunction

  function automatic logic [N_ARRAY-1:0] thermo(
    input logic [IDX_WIDTH-1:0] k
  );
    logic [N_ARRAY-1:0] t;
    for (int i = 0; i < N_ARRAY; i++)
      t[i] = (IDX_WIDTH'(i) < k);
    return t;
  endfunction

  assign mode_n    = (mode == M_UP || mode == M_TRI) ? mode : M_DOWN;
  assign last      = (mode_q == M_TRI) ? N2 : NK;
  assign dwell_end = (cnt_q == dwell_q - 1'b1);
  assign fin       = dwell_end && (idx_q == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= M_DOWN;
      loop_q  <= 1'b0;
      dwell_q <= DWELL_WIDTH'(1);
      cnt_q   <= '0;
      idx_q   <= '0;
      ctrl_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      loop_q  <= loop_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start && !abort)
          state_d = RUN;
      end
      (state_q == RUN): begin
        if (abort)
          state_d = IDLE;
        else if (fin && !loop_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    loop_d  = loop_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ctrl_d  = ctrl_q;
    busy_d  = (state_d == RUN);
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start && !abort) begin
          mode_d  = mode_n;
          loop_d  = loop;
          dwell_d = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
          cnt_d   = '0;
          idx_d   = '0;
          ctrl_d  = thermo(level(mode_n, '0));
        end
      end
      (state_q == RUN): begin
        if (abort) begin
          done_d = 1'b0;
        end else if (fin) begin
          done_d = 1'b1;
          if (loop_q) begin
            cnt_d  = '0;
            idx_d  = '0;
            ctrl_d = thermo(level(mode_q, '0));
          end
        end else if (dwell_end) begin
          cnt_d  = '0;
          idx_d  = idx_q + 1'b1;
          ctrl_d = thermo(level(mode_q, idx_q + 1'b1));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ctrl     = ctrl_q;
  assign step_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
